// File: rtl/ram_initiator.sv
// ram_initiator: valid/ready front end for a single-port 4-bit RAM cell array,
// with a built-in self-test that writes a seeded pattern to every word,
// reads it back, and reports a pass flag and a saturating mismatch count.
module ram_initiator #(
    parameter int                ADDR_W = 3,
    parameter int                DATA_W = 4,
    parameter logic [DATA_W-1:0] SEED   = 4'b1010
) (
    input  logic              CLK_,
    input  logic              CLR,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              bist_start,
    output logic              bist_busy,
    output logic              bist_done,
    output logic              bist_pass,
    output logic [ADDR_W:0]   bist_err_cnt,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    // Counter is one bit wider than the address so the last word is
    // detected without the count aliasing back to zero.
    localparam int             CW   = ADDR_W + 1;
    localparam logic [CW-1:0]  LAST = CW'((1 << ADDR_W) - 1);

    typedef enum logic [2:0] {
        IDLE, WRITE, READ, BIST_WR, BIST_RD, BIST_END
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                ram_rw_q, ram_rw_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_din_q, ram_din_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [CW-1:0]       err_q, err_d;
    logic                pass_q, pass_d;

    // BIST pattern: low address bits zero-extended to the word, XOR seed.
    function automatic logic [DATA_W-1:0] pat(input logic [CW-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < DATA_W && i < ADDR_W; i++) v[i] = a[i];
        return v ^ SEED;
    endfunction

    assign cnt_inc = cnt_q + 1'b1;

    // Next-state, RAM pin and status computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ram_rw_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        err_d       = err_q;
        pass_d      = pass_q;
        case (state_q)
            IDLE: begin
                // Self-test wins over a simultaneous request; the request
                // stays pending and is taken once the test finishes.
                if (bist_start) begin
                    state_d    = BIST_WR;
                    cnt_d      = '0;
                    ram_rw_d   = 1'b1;
                    ram_addr_d = '0;
                    ram_din_d  = pat('0);
                    err_d      = '0;
                    pass_d     = 1'b0;
                end else if (req_valid) begin
                    state_d    = req_we ? WRITE : READ;
                    ram_rw_d   = req_we;
                    ram_addr_d = req_addr;
                    ram_din_d  = req_wdata;
                end
            end
            WRITE: state_d = IDLE;
            READ: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = ram_dout;
            end
            BIST_WR: begin
                if (cnt_q == LAST) begin
                    state_d    = BIST_RD;
                    cnt_d      = '0;
                    ram_addr_d = '0;
                end else begin
                    cnt_d      = cnt_inc;
                    ram_rw_d   = 1'b1;
                    ram_addr_d = cnt_inc[ADDR_W-1:0];
                    ram_din_d  = pat(cnt_inc);
                end
            end
            BIST_RD: begin
                if (ram_dout != pat(cnt_q) && err_q != '1) err_d = err_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = BIST_END;
                    pass_d  = (err_d == '0);
                end else begin
                    cnt_d      = cnt_inc;
                    ram_addr_d = cnt_inc[ADDR_W-1:0];
                end
            end
            BIST_END: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State and output registers; CLR aborts any operation immediately.
    always_ff @(posedge CLK_ or posedge CLR) begin
        if (CLR) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ram_rw_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            err_q       <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ram_rw_q    <= ram_rw_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_q       <= err_d;
            pass_q      <= pass_d;
        end
    end

    // Ready is withheld when bist_start is present so that a request is
    // never seen as accepted in a cycle where the self-test takes priority.
    assign req_ready    = (state_q == IDLE) && !bist_start;
    assign bist_busy    = (state_q == BIST_WR) || (state_q == BIST_RD);
    assign bist_done    = (state_q == BIST_END);
    assign bist_pass    = pass_q;
    assign bist_err_cnt = err_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign ram_rw       = ram_rw_q;
    assign ram_addr     = ram_addr_q;
    assign ram_din      = ram_din_q;

endmodule

// File: tb/tb_ram_initiator.sv
// Directed bench for ram_initiator with a behavioural RAM cell array:
// writes on the rising edge when R_W_=1, updates data_out on the falling
// edge when R_W_=0, and an optional stuck-at-0 fault on data_out[0].
module tb_ram_initiator;
    localparam int AW = 3;
    localparam int DW = 4;

    logic          CLK_, CLR;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          bist_start, bist_busy, bist_done, bist_pass;
    logic [AW:0]   bist_err_cnt;
    logic          ram_rw;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    logic [DW-1:0] mem [0:7];
    logic [DW-1:0] dout_r;
    logic          fault;

    int n_chk  = 0;
    int n_fail = 0;

    ram_initiator dut (
        .CLK_(CLK_), .CLR(CLR),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .bist_start(bist_start), .bist_busy(bist_busy), .bist_done(bist_done),
        .bist_pass(bist_pass), .bist_err_cnt(bist_err_cnt),
        .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    initial CLK_ = 1'b0;
    always #5 CLK_ = ~CLK_;

    // RAM cell model
    always @(posedge CLK_) if (ram_rw) mem[ram_addr] <= ram_din;
    always @(negedge CLK_) if (!ram_rw) dout_r <= mem[ram_addr];
    assign ram_dout = fault ? (dout_r & 4'b1110) : dout_r;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_bist_busy"}, bist_busy, 0);
        chk({tag, "_bist_done"}, bist_done, 0);
        chk({tag, "_bist_pass"}, bist_pass, 0);
        chk({tag, "_bist_err"}, bist_err_cnt, 0);
        chk({tag, "_ram_rw"}, ram_rw, 0);
        chk({tag, "_ram_addr"}, ram_addr, 0);
        chk({tag, "_ram_din"}, ram_din, 0);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge CLK_);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        #1 chk("wr_ready", req_ready, 1);
        @(posedge CLK_);
        #1 req_valid = 1'b0;
        @(negedge CLK_);
        chk("wr_busy_ready", req_ready, 0);
        chk("wr_ram_rw", ram_rw, 1);
        chk("wr_ram_addr", ram_addr, a);
        chk("wr_ram_din", ram_din, d);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
        @(negedge CLK_);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        #1 chk("rd_ready", req_ready, 1);
        @(posedge CLK_);
        #1 req_valid = 1'b0;
        @(negedge CLK_);
        chk("rd_busy_ready", req_ready, 0);
        chk("rd_ram_rw", ram_rw, 0);
        chk("rd_ram_addr", ram_addr, a);
        chk("rd_rsp_early", rsp_valid, 0);
        @(negedge CLK_);
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_rdata", rsp_rdata, e);
        @(negedge CLK_);
        chk("rd_rsp_pulse", rsp_valid, 0);
    endtask

    // Full self-test with cycle-exact checks of busy, RAM pins and done.
    task automatic run_bist(input logic exp_pass, input logic [AW:0] exp_err);
        logic [DW-1:0] e;
        @(negedge CLK_);
        bist_start = 1'b1;
        @(posedge CLK_);
        #1 bist_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK_);
            chk("bist_busy", bist_busy, 1);
            chk("bist_no_rsp", rsp_valid, 0);
            chk("bist_no_done", bist_done, 0);
            if (i < 8) begin
                e = 4'(i) ^ 4'hA;
                chk("bist_wr_rw", ram_rw, 1);
                chk("bist_wr_addr", ram_addr, i);
                chk("bist_wr_din", ram_din, e);
            end else begin
                chk("bist_rd_rw", ram_rw, 0);
                chk("bist_rd_addr", ram_addr, i - 8);
            end
        end
        @(negedge CLK_);
        chk("bist_done", bist_done, 1);
        chk("bist_end_busy", bist_busy, 0);
        chk("bist_pass", bist_pass, exp_pass);
        chk("bist_err", bist_err_cnt, exp_err);
        @(negedge CLK_);
        chk("bist_done_pulse", bist_done, 0);
        chk("bist_pass_hold", bist_pass, exp_pass);
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;   // write data, or expected read data
    } vec_t;

    vec_t tbl [8];
    vec_t bb  [4];

    initial begin
        int idx, cnt, dcnt;
        logic got;

        tbl[0] = '{1'b1, 3'd5, 4'hA};
        tbl[1] = '{1'b0, 3'd5, 4'hA};
        tbl[2] = '{1'b1, 3'd0, 4'h3};
        tbl[3] = '{1'b1, 3'd7, 4'hF};
        tbl[4] = '{1'b0, 3'd0, 4'h3};
        tbl[5] = '{1'b0, 3'd7, 4'hF};
        tbl[6] = '{1'b1, 3'd5, 4'h1};
        tbl[7] = '{1'b0, 3'd5, 4'h1};
        bb[0]  = '{1'b1, 3'd2, 4'h6};
        bb[1]  = '{1'b0, 3'd2, 4'h6};
        bb[2]  = '{1'b1, 3'd3, 4'h9};
        bb[3]  = '{1'b0, 3'd3, 4'h9};

        for (int i = 0; i < 8; i++) mem[i] = '0;
        dout_r = '0; fault = 1'b0;
        CLR = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; bist_start = 1'b0;

        // Reset
        #2 CLR = 1'b1;
        #2 chk_reset("rst");
        @(negedge CLK_);
        CLR = 1'b0;
        #1 chk("rst_release_ready", req_ready, 1);

        // Single requests from the table
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].we) do_write(tbl[i].addr, tbl[i].data);
            else           do_read(tbl[i].addr, tbl[i].data);
        end

        // Back-to-back: req_valid held high, next request presented while held off
        for (int c = 0; c <= 8; c++) begin
            @(negedge CLK_);
            if (c <= 6) begin
                idx = (c + 1) / 2;
                req_valid = 1'b1; req_we = bb[idx].we;
                req_addr = bb[idx].addr; req_wdata = bb[idx].data;
            end else begin
                req_valid = 1'b0;
            end
            #1;
            if (c <= 7) chk("bb_ready", req_ready, (c % 2 == 0) ? 1 : 0);
            if (c == 4 || c == 8) begin
                chk("bb_rsp_valid", rsp_valid, 1);
                chk("bb_rsp_rdata", rsp_rdata, bb[c/2 - 1].data);
            end else begin
                chk("bb_rsp_idle", rsp_valid, 0);
            end
        end

        // Self-test, good RAM
        run_bist(1'b1, 4'd0);

        // Self-test, stuck-at-0 on data bit 0, with a competing read request
        fault = 1'b1;
        @(negedge CLK_);
        bist_start = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd1;
        @(posedge CLK_);
        #1 bist_start = 1'b0;
        @(negedge CLK_);
        chk("prio_bist_busy", bist_busy, 1);
        chk("prio_ram_rw", ram_rw, 1);
        chk("prio_held_ready", req_ready, 0);
        got = 1'b0; cnt = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge CLK_);
            if (rsp_valid) cnt++;
            if (bist_done) got = 1'b1;
        end
        chk("fault_done_seen", got, 1);
        chk("fault_rsp_during_bist", cnt, 0);
        chk("fault_pass", bist_pass, 0);
        chk("fault_err", bist_err_cnt, 4);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge CLK_);
            if (rsp_valid) begin
                got = 1'b1;
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        chk("held_req_rsp_seen", got, 1);
        chk("held_req_rdata", rsp_rdata, 4'hA);

        // Abort self-test with CLR during read cycle 3 (err count already 1)
        @(negedge CLK_);
        bist_start = 1'b1;
        @(posedge CLK_);
        #1 bist_start = 1'b0;
        repeat (12) @(negedge CLK_);
        chk("abort_pre_err", bist_err_cnt, 1);
        CLR = 1'b1;
        #1 chk_reset("abort");
        @(negedge CLK_);
        CLR = 1'b0;
        #1 chk("abort_release_ready", req_ready, 1);
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK_);
            if (bist_done || bist_busy) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);
        chk("abort_err_stays", bist_err_cnt, 0);
        fault = 1'b0;
        run_bist(1'b1, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
